// File: rtl/breath_pkg.sv
// breath_pkg: shared types and helpers for the breathing LED sequencer.
// Build option: define BREATH_GAMMA_EN to compile the square-law duty curve.
package breath_pkg;

    typedef enum logic [2:0] {
        IDLE,
        UP,
        HOLD_HI,
        DOWN,
        HOLD_LO
    } breath_st_e;

`ifdef BREATH_GAMMA_EN
    // Square-law perceptual mapping: (lin * lin) >> cnt_w, valid for cnt_w <= 16.
    function automatic logic [31:0] breath_gamma(input logic [31:0] lin,
                                                 input int unsigned cnt_w);
        logic [31:0] sq;
        sq = lin * lin;
        return sq >> cnt_w;
    endfunction
`endif

endpackage

// File: rtl/breath_pwm.sv
// breath_pwm: free-running PWM frame counter, frame-boundary strobe and
// registered compare output. Counter is held at zero while not running.
module breath_pwm #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [CNT_W-1:0] duty,
    output logic             frame,
    output logic             led
);

    logic [CNT_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic             led_q, led_d;

    // Counter advance and compare; both forced low outside a run.
    always_comb begin
        pwm_cnt_d = '0;
        led_d     = 1'b0;
        if (run) begin
            pwm_cnt_d = pwm_cnt_q + CNT_W'(1);
            led_d     = (pwm_cnt_q < duty);
        end
    end

    // Counter and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_cnt_q <= '0;
            led_q     <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            led_q     <= led_d;
        end
    end

    // Frame boundary is the last count of the frame; duty updates land on the wrap.
    assign frame = run && (pwm_cnt_q == '1);
    assign led   = led_q;

endmodule

// File: rtl/breath_seq_ctrl.sv
// breath_seq_ctrl: breathing-pattern sequencer (fade-in, bright hold,
// fade-out, dark hold) with start/stop and breath-count control.
// Build option: define BREATH_GAMMA_EN to apply the square-law duty curve.
module breath_seq_ctrl
    import breath_pkg::*;
#(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned DUTY_MAX    = 255,
    parameter int unsigned STEP_FRAMES = 4,
    parameter int unsigned HOLD_FRAMES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [7:0]       cycles,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] duty,
    output logic             led
);

    localparam int unsigned STEP_W = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
    localparam int unsigned HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [CNT_W-1:0]  LIN_MAX   = CNT_W'(DUTY_MAX);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_FRAMES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

    breath_st_e        state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [7:0]        brc_q, brc_d;
    logic [7:0]        cyc_q, cyc_d;
    logic [CNT_W-1:0]  lin_q, lin_d;
    logic              stop_q, stop_d;
    logic              done_q, done_d;

    logic              frame;
    logic              tick;
    logic              stopping;
    logic [7:0]        brc_inc;
    logic [CNT_W-1:0]  lin_inc;
    logic [CNT_W-1:0]  duty_eff;

    breath_pwm #(
        .CNT_W (CNT_W)
    ) u_pwm (
        .clk   (clk),
        .rst   (rst),
        .run   (state_q != IDLE),
        .duty  (duty_eff),
        .frame (frame),
        .led   (led)
    );

    // Next-state, step/hold/breath counters and linear duty schedule.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        hold_d   = hold_q;
        brc_d    = brc_q;
        cyc_d    = cyc_q;
        lin_d    = lin_q;
        stop_d   = stop_q;
        done_d   = 1'b0;
        // A stop request is sticky for the rest of the run, so a re-asserted
        // en during the fade-out cannot resume the breath.
        stopping = stop_q || !en;
        tick     = frame && (step_q == STEP_LAST);
        brc_inc  = brc_q + 8'd1;
        lin_inc  = lin_q + CNT_W'(1);

        if (state_q != IDLE && !en) begin
            stop_d = 1'b1;
        end
        if (frame && (state_q == UP || state_q == DOWN)) begin
            step_d = tick ? '0 : step_q + STEP_W'(1);
        end
        if (frame && (state_q == HOLD_HI || state_q == HOLD_LO)) begin
            hold_d = (hold_q == HOLD_LAST) ? '0 : hold_q + HOLD_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = UP;
                    cyc_d   = cycles;
                    brc_d   = '0;
                    step_d  = '0;
                    hold_d  = '0;
                    lin_d   = '0;
                    stop_d  = 1'b0;
                end
            end
            UP: begin
                if (frame && stopping) begin
                    state_d = DOWN;
                    step_d  = '0;
                end else if (tick) begin
                    lin_d = lin_inc;
                    if (lin_inc == LIN_MAX) begin
                        state_d = HOLD_HI;
                        hold_d  = '0;
                    end
                end
            end
            HOLD_HI: begin
                if (frame && (stopping || hold_q == HOLD_LAST)) begin
                    state_d = DOWN;
                    hold_d  = '0;
                    step_d  = '0;
                end
            end
            DOWN: begin
                if (tick) begin
                    // Early stop may enter DOWN at low duty; clamp instead of wrapping.
                    if (lin_q <= CNT_W'(1)) begin
                        lin_d   = '0;
                        state_d = HOLD_LO;
                        hold_d  = '0;
                    end else begin
                        lin_d = lin_q - CNT_W'(1);
                    end
                end
            end
            HOLD_LO: begin
                if (frame && hold_q == HOLD_LAST) begin
                    brc_d  = brc_inc;
                    hold_d = '0;
                    step_d = '0;
                    if ((cyc_q != 8'd0 && brc_inc == cyc_q) || stopping) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = UP;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            hold_q  <= '0;
            brc_q   <= '0;
            cyc_q   <= '0;
            lin_q   <= '0;
            stop_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            hold_q  <= hold_d;
            brc_q   <= brc_d;
            cyc_q   <= cyc_d;
            lin_q   <= lin_d;
            stop_q  <= stop_d;
            done_q  <= done_d;
        end
    end

    // Effective duty mapping; forced to zero in IDLE.
    always_comb begin
`ifdef BREATH_GAMMA_EN
        duty_eff = CNT_W'(breath_gamma(32'(lin_q), CNT_W));
`else
        duty_eff = lin_q;
`endif
        if (state_q == IDLE) begin
            duty_eff = '0;
        end
    end

    assign duty = duty_eff;
    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_breath_seq_ctrl.sv
// Directed testbench for breath_seq_ctrl with CNT_W=4, DUTY_MAX=15,
// STEP_FRAMES=1, HOLD_FRAMES=2 (one breath = 34 frames = 544 clocks).
module tb_breath_seq_ctrl;

    localparam int unsigned CNT_W = 4;
`ifdef BREATH_GAMMA_EN
    localparam int PEAK = 14;  // 15*15>>4
    localparam int D5   = 1;   // 5*5>>4
    localparam int D1   = 0;   // 1*1>>4
`else
    localparam int PEAK = 15;
    localparam int D5   = 5;
    localparam int D1   = 1;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [7:0]       cycles;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] duty;
    logic             led;

    int checks = 0;
    int errors = 0;

    breath_seq_ctrl #(
        .CNT_W       (4),
        .DUTY_MAX    (15),
        .STEP_FRAMES (1),
        .HOLD_FRAMES (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .cycles (cycles),
        .busy   (busy),
        .done   (done),
        .duty   (duty),
        .led    (led)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; cycles = 8'd0;
        @(negedge clk); @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
        checks++; if (duty !== 4'd0) begin errors++; $display("FAIL reset_duty: got %0d expected 0", duty); end
        checks++; if (led !== 1'b0) begin errors++; $display("FAIL reset_led: got %0b expected 0", led); end
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_en_busy: got %0b expected 0", busy); end
    endtask

    task automatic test_single_breath();
        int busy_cnt = 0, done_cnt = 0, done_k = -1, peak = 0;
        int led5 = 0, led_hi = 0, led_lo = 0, duty80 = -1, duty544 = -1;
        logic led81 = 1'b0, led86 = 1'b1, led256 = 1'b1;
        cycles = 8'd1; en = 1'b1;
        for (int k = 0; k < 700; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin done_cnt++; if (done_k < 0) done_k = k; en = 1'b0; end
            if (int'(duty) > peak) peak = int'(duty);
            if (k >= 81 && k <= 96 && led) led5++;
            if (k >= 241 && k <= 256 && led) led_hi++;
            if (((k >= 1 && k <= 16) || (k >= 513 && k <= 560)) && led) led_lo++;
            if (k == 80) duty80 = int'(duty);
            if (k == 81) led81 = led;
            if (k == 86) led86 = led;
            if (k == 256) led256 = led;
            if (k == 544) duty544 = int'(duty);
        end
        checks++; if (busy_cnt !== 544) begin errors++; $display("FAIL single_busy_clocks: got %0d expected 544", busy_cnt); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL single_done_count: got %0d expected 1", done_cnt); end
        checks++; if (done_k !== 544) begin errors++; $display("FAIL single_done_cycle: got %0d expected 544", done_k); end
        checks++; if (peak !== PEAK) begin errors++; $display("FAIL single_peak_duty: got %0d expected %0d", peak, PEAK); end
        checks++; if (duty80 !== D5) begin errors++; $display("FAIL duty_at_lin5: got %0d expected %0d", duty80, D5); end
        checks++; if (led5 !== D5) begin errors++; $display("FAIL led_high_lin5: got %0d expected %0d", led5, D5); end
        checks++; if (led81 !== 1'b1) begin errors++; $display("FAIL led_lag_first: got %0b expected 1", led81); end
        checks++; if (led86 !== 1'b0) begin errors++; $display("FAIL led_lag_last: got %0b expected 0", led86); end
        checks++; if (led_hi !== PEAK) begin errors++; $display("FAIL led_hold_hi_count: got %0d expected %0d", led_hi, PEAK); end
        checks++; if (led256 !== 1'b0) begin errors++; $display("FAIL led_hold_hi_low_slot: got %0b expected 0", led256); end
        checks++; if (led_lo !== 0) begin errors++; $display("FAIL led_duty0_toggle: got %0d expected 0", led_lo); end
        checks++; if (duty544 !== 0) begin errors++; $display("FAIL idle_duty: got %0d expected 0", duty544); end
    endtask

    task automatic test_count_three();
        int busy_cnt = 0, done_cnt = 0, done_k = -1;
        cycles = 8'd3; en = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin done_cnt++; if (done_k < 0) done_k = k; en = 1'b0; end
            if (done_k >= 0 && k > done_k + 20) break;
        end
        checks++; if (busy_cnt !== 1632) begin errors++; $display("FAIL three_busy_clocks: got %0d expected 1632", busy_cnt); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL three_done_count: got %0d expected 1", done_cnt); end
        checks++; if (done_k !== 1632) begin errors++; $display("FAIL three_done_cycle: got %0d expected 1632", done_k); end
    endtask

    task automatic test_endless_stop();
        int busy_cnt = 0, done_cnt = 0, done_k = -1;
        int d250 = -1, d260 = -1, d485 = -1, d500 = -1;
        cycles = 8'd0; en = 1'b1;
        for (int k = 0; k < 1200; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin done_cnt++; if (done_k < 0) done_k = k; en = 1'b0; end
            if (k == 250) begin d250 = int'(duty); en = 1'b0; end
            if (k == 260) d260 = int'(duty);
            if (k == 400) en = 1'b1;
            if (k == 485) d485 = int'(duty);
            if (k == 500) d500 = int'(duty);
            if (done_k >= 0 && k > done_k + 20) break;
        end
        checks++; if (d250 !== PEAK) begin errors++; $display("FAIL stop_hold_hi_duty: got %0d expected %0d", d250, PEAK); end
        checks++; if (d260 !== PEAK) begin errors++; $display("FAIL stop_down_first: got %0d expected %0d", d260, PEAK); end
        checks++; if (d485 !== D1) begin errors++; $display("FAIL stop_down_last: got %0d expected %0d", d485, D1); end
        checks++; if (d500 !== 0) begin errors++; $display("FAIL stop_hold_lo_duty: got %0d expected 0", d500); end
        checks++; if (done_k !== 528) begin errors++; $display("FAIL stop_done_cycle: got %0d expected 528", done_k); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL stop_done_count: got %0d expected 1", done_cnt); end
        checks++; if (busy_cnt !== 528) begin errors++; $display("FAIL stop_busy_clocks: got %0d expected 528", busy_cnt); end
    endtask

    task automatic test_reset_mid_run();
        bit seen_done = 1'b0;
        cycles = 8'd0; en = 1'b1;
        repeat (300) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %0b expected 1", busy); end
        checks++; if (duty === 4'd0) begin errors++; $display("FAIL mid_duty_before: got %0d expected nonzero", duty); end
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %0b expected 0", busy); end
        checks++; if (led !== 1'b0) begin errors++; $display("FAIL mid_rst_led: got %0b expected 0", led); end
        checks++; if (duty !== 4'd0) begin errors++; $display("FAIL mid_rst_duty: got %0d expected 0", duty); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_rst_done: got %0b expected 0", done); end
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL release_busy_now: got %0b expected 0", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL release_busy_next: got %0b expected 1", busy); end
        checks++; if (duty !== 4'd0) begin errors++; $display("FAIL release_duty: got %0d expected 0", duty); end
        en = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (done) begin seen_done = 1'b1; break; end
        end
        checks++; if (seen_done !== 1'b1) begin errors++; $display("FAIL early_stop_done: got %0b expected 1", seen_done); end
    endtask

    initial begin
        test_reset();
        test_single_breath();
        test_count_three();
        test_endless_stop();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
